ps2_kbd_ctrl: RTL and testbench

Keyboard protocol controller that sits between the `ps2_rx` byte receiver and the elevator control logic. It gates the receiver with `rx_en` and parses PS/2 scan-code set 2 byte streams. Prefix sequences (`E0`, `F0`, `E0 F0`, `E1` pause) become single key events, which are buffered in a small FIFO. The elevator FSM drains that FIFO with a ready/valid handshake.

---
 rtl/kbd_pkg.sv | 36 +++
 rtl/kbd_fifo.sv | 45 ++++
 rtl/ps2_kbd_ctrl.sv | 144 ++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 keyboard controller: scan-code prefixes,
// event layout and parser state encoding.
package kbd_pkg;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;
  localparam logic [7:0] BYTE_00 = 8'h00;
  localparam logic [7:0] BYTE_FF = 8'hFF;

  localparam int unsigned EV_W   = 10;
  localparam int unsigned EV_EXT = 9;
  localparam int unsigned EV_BRK = 8;

  // Pause key (E1 ...) is 8 bytes long; the E1 itself starts the skip.
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_SKIP    = 3'd4
  } kbd_state_e;

  function automatic logic [EV_W-1:0] ev_pack(input logic ext, input logic brk,
                                              input logic [7:0] code);
    logic [EV_W-1:0] ev;
    ev         = '0;
    ev[EV_EXT] = ext;
    ev[EV_BRK] = brk;
    ev[7:0]    = code;
    return ev;
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Key-event FIFO: circular buffer with an extra pointer MSB for full/empty.
module kbd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop_c;
  logic             do_push_c;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop_c  = pop && !empty;
  // A full FIFO can still accept a write when the head leaves in the same cycle.
  assign do_push_c = push && (!full || do_pop_c);
  assign pop_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push_c) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop_c) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 set-2 scan-code parser: folds prefix bytes into single key events,
// buffers them in a FIFO and throttles the receiver when the buffer fills.
module ps2_kbd_ctrl
  import kbd_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            rx_done_tick,
  input  logic [7:0]      rx_data,
  output logic            rx_en,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [EV_W-1:0] ev_data,
  output logic            kbd_err,
  output logic            ovf,
  input  logic            ovf_clr
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  kbd_state_e      state;
  logic [2:0]      skip_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            push_c;
  logic [EV_W-1:0] push_data_c;
  logic            err_byte_c;
  logic            tmo_hit_c;
  logic            pop_c;
  logic            fifo_full;
  logic            fifo_empty;

  kbd_fifo #(.DEPTH(DEPTH), .WIDTH(EV_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .push_data (push_data_c),
    .pop       (pop_c),
    .pop_data  (ev_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign pop_c    = ev_valid && ev_ready;

  // Event decode for the byte arriving this cycle
  always_comb begin
    push_c      = 1'b0;
    push_data_c = ev_pack(1'b0, 1'b0, rx_data);
    err_byte_c  = 1'b0;
    if (rx_done_tick) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == BYTE_00 || rx_data == BYTE_FF) begin
            err_byte_c = 1'b1;
          end else if (rx_data != BYTE_E0 && rx_data != BYTE_F0 && rx_data != BYTE_E1) begin
            push_c = 1'b1;
          end
        end
        ST_EXT: begin
          push_c      = (rx_data != BYTE_F0);
          push_data_c = ev_pack(1'b1, 1'b0, rx_data);
        end
        ST_BRK: begin
          push_c      = 1'b1;
          push_data_c = ev_pack(1'b0, 1'b1, rx_data);
        end
        ST_EXT_BRK: begin
          push_c      = 1'b1;
          push_data_c = ev_pack(1'b1, 1'b1, rx_data);
        end
        default: ;
      endcase
    end
  end

  // A byte arriving on the expiry cycle restarts the count instead of aborting.
  assign tmo_hit_c = (state != ST_IDLE) && !rx_done_tick &&
                     (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  // Parser state, pause skip counter and inter-byte timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
      tmo_cnt  <= '0;
      kbd_err  <= 1'b0;
    end else begin
      kbd_err <= err_byte_c || tmo_hit_c;
      if (rx_done_tick) begin
        tmo_cnt <= '0;
        case (state)
          ST_IDLE: begin
            if (rx_data == BYTE_E0) begin
              state <= ST_EXT;
            end else if (rx_data == BYTE_F0) begin
              state <= ST_BRK;
            end else if (rx_data == BYTE_E1) begin
              state    <= ST_SKIP;
              skip_cnt <= PAUSE_TAIL;
            end
          end
          ST_EXT:     state <= (rx_data == BYTE_F0) ? ST_EXT_BRK : ST_IDLE;
          ST_BRK:     state <= ST_IDLE;
          ST_EXT_BRK: state <= ST_IDLE;
          ST_SKIP: begin
            if (skip_cnt == 3'd1) begin
              state    <= ST_IDLE;
              skip_cnt <= '0;
            end else begin
              skip_cnt <= skip_cnt - 3'd1;
            end
          end
          default:    state <= ST_IDLE;
        endcase
      end else if (state == ST_IDLE) begin
        tmo_cnt <= '0;
      end else if (tmo_hit_c) begin
        state    <= ST_IDLE;
        skip_cnt <= '0;
        tmo_cnt  <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

  // Receiver throttle and sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_en <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      rx_en <= enable && !fifo_full;
      if (push_c && fifo_full && !pop_c) ovf <= 1'b1;
      else if (ovf_clr)                  ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: directed protocol cases plus random
// key streams checked against an event-level queue model.
module tb_ps2_kbd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       rx_en;
  logic       ev_valid;
  logic       ev_ready;
  logic [9:0] ev_data;
  logic       kbd_err;
  logic       ovf;
  logic       ovf_clr;

  int checks   = 0;
  int failures = 0;
  logic [9:0] exp_q[$];

  ps2_kbd_ctrl #(.DEPTH(4), .TIMEOUT_CYC(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .rx_en        (rx_en),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_data      (ev_data),
    .kbd_err      (kbd_err),
    .ovf          (ovf),
    .ovf_clr      (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [9:0] exp);
    chk({tag, "_valid"}, 32'(ev_valid), 32'd1);
    chk(tag, 32'(ev_data), 32'(exp));
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
  endtask

  task automatic drain_model(input string tag);
    while (exp_q.size() > 0) pop_check(tag, exp_q.pop_front());
    chk({tag, "_empty"}, 32'(ev_valid), 32'd0);
  endtask

  // Encode a key event as its byte stream, with short random gaps.
  task automatic send_key(input logic ext, input logic brk, input logic [7:0] code);
    if (ext) begin send_byte(8'hE0); idle($urandom_range(0, 3)); end
    if (brk) begin send_byte(8'hF0); idle($urandom_range(0, 3)); end
    send_byte(code);
  endtask

  function automatic logic [7:0] rand_code();
    logic [7:0] c;
    do c = 8'($urandom_range(1, 254));
    while (c == 8'hE0 || c == 8'hF0 || c == 8'hE1);
    return c;
  endfunction

  initial begin
    logic [7:0] pause_seq [8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    reset = 1'b1; enable = 1'b1; rx_done_tick = 1'b0; rx_data = 8'h00;
    ev_ready = 1'b0; ovf_clr = 1'b0;
    idle(3);
    chk("rst_rx_en", 32'(rx_en), 32'd0);
    chk("rst_ev_valid", 32'(ev_valid), 32'd0);
    chk("rst_ev_data", 32'(ev_data), 32'd0);
    chk("rst_kbd_err", 32'(kbd_err), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    step();
    chk("rx_en_rise", 32'(rx_en), 32'd1);

    // Plain key with consumer ready: valid for exactly one cycle
    ev_ready = 1'b1;
    send_byte(8'h1C);
    chk("plain_valid", 32'(ev_valid), 32'd1);
    chk("plain_data", 32'(ev_data), 32'h01C);
    step();
    chk("plain_one_cycle", 32'(ev_valid), 32'd0);
    ev_ready = 1'b0;

    // Extended break
    send_byte(8'hE0);
    chk("extbrk_pfx1", 32'(ev_valid), 32'd0);
    send_byte(8'hF0);
    chk("extbrk_pfx2", 32'(ev_valid), 32'd0);
    send_byte(8'h75);
    pop_check("extbrk", 10'h375);

    // Pause sequence yields nothing
    for (int i = 0; i < 8; i++) begin
      send_byte(pause_seq[i]);
      chk("pause_silent", 32'(ev_valid), 32'd0);
    end
    send_byte(8'h1C);
    pop_check("after_pause", 10'h01C);
    chk("after_pause_empty", 32'(ev_valid), 32'd0);

    // Timeout after a lone break prefix
    send_byte(8'hF0);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("tmo_early", 32'(kbd_err), 32'd0);
    end
    step();
    chk("tmo_err", 32'(kbd_err), 32'd1);
    step();
    chk("tmo_err_pulse", 32'(kbd_err), 32'd0);
    send_byte(8'h1C);
    pop_check("tmo_after", 10'h01C);

    // Overflow handling with consumer stalled
    for (int i = 0; i < 4; i++) send_byte(8'(8'h11 + i));
    step();
    chk("ovf_rx_en_low", 32'(rx_en), 32'd0);
    chk("ovf_pre", 32'(ovf), 32'd0);
    send_byte(8'h15);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_head", 32'(ev_data), 32'h011);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);
    ev_ready = 1'b1;
    send_byte(8'h16);
    ev_ready = 1'b0;
    chk("pushpop_full_no_ovf", 32'(ovf), 32'd0);
    ovf_clr = 1'b1;
    send_byte(8'h17);
    ovf_clr = 1'b0;
    chk("ovf_set_wins", 32'(ovf), 32'd1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("ovf_clr2", 32'(ovf), 32'd0);
    exp_q = '{10'h012, 10'h013, 10'h014, 10'h016};
    drain_model("ovf_order");
    step();
    chk("ovf_rx_en_back", 32'(rx_en), 32'd1);

    // Error byte, then reset in the middle of a sequence
    send_byte(8'hFF);
    chk("errbyte_pulse", 32'(kbd_err), 32'd1);
    chk("errbyte_noev", 32'(ev_valid), 32'd0);
    step();
    chk("errbyte_pulse_end", 32'(kbd_err), 32'd0);
    send_byte(8'h2A);
    send_byte(8'hE0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(ev_valid), 32'd0);
    chk("async_rst_rx_en", 32'(rx_en), 32'd0);
    @(negedge clk) reset = 1'b0;
    step();
    send_byte(8'h75);
    pop_check("post_rst", 10'h075);

    // Random key streams against the event model
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        for (int i = 0; i < 8; i++) send_byte(pause_seq[i]);
      end else if (r == 1) begin
        send_byte(($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF);
        chk("rnd_err", 32'(kbd_err), 32'd1);
      end else begin
        logic       ext, brk;
        logic [7:0] c;
        ext = 1'($urandom_range(0, 1));
        brk = 1'($urandom_range(0, 1));
        c   = rand_code();
        send_key(ext, brk, c);
        exp_q.push_back({ext, brk, c});
      end
      idle($urandom_range(0, 2));
      if (exp_q.size() >= int'($urandom_range(1, 3))) drain_model("rnd_ev");
    end
    drain_model("rnd_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
